// File: rtl/gpio_logic_array_pkg.sv
// gpio_logic_array_pkg: channel config field layout and op encodings
package gpio_logic_array_pkg;
    localparam int CFG_BITS = 4;
    localparam int EN_BIT = 3;
    localparam int OP_MSB = 2;
    localparam int OP_LSB = 0;
    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_TOGGLE = 3'd6,
        OP_SR     = 3'd7
    } op_e;
    function automatic logic comb_op(op_e op, logic a, logic b);
        return op == OP_AND  ? a & b :
               op == OP_OR   ? a | b :
               op == OP_XOR  ? a ^ b :
               op == OP_NAND ? ~(a & b) :
               op == OP_NOR  ? ~(a | b) :
               op == OP_XNOR ? ~(a ^ b) : 1'b0;
    endfunction
endpackage

// File: rtl/gpio_logic_array_channel.sv
// gpio_logic_channel: pad sync, edge detect and stateful logic op for one channel
module gpio_logic_channel
    import gpio_logic_array_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_i,
    input  logic                b_i,
    input  logic [CFG_BITS-1:0] cfg_i,
    input  logic                clr_i,
    output logic                out_o,
    output logic                oeb_o
);
    logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
    logic a_s, b_s, a_prev_q, out_q, out_d, en;
    op_e op;
    assign a_s = a_sync_q[SYNC_STAGES-1];
    assign b_s = b_sync_q[SYNC_STAGES-1];
    assign en = cfg_i[EN_BIT];
    assign op = op_e'(cfg_i[OP_MSB:OP_LSB]);
    always_comb begin
        out_d = (!en || clr_i)   ? 1'b0 :
                op == OP_TOGGLE ? out_q ^ (a_s & ~a_prev_q & b_s) :
                op == OP_SR     ? a_s | (~b_s & out_q) :
                                  comb_op(op, a_s, b_s);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
            a_prev_q <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_i};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_i};
            a_prev_q <= a_s;
            out_q    <= out_d;
        end
    end
    assign out_o = out_q;
    assign oeb_o = ~en;
endmodule

// File: rtl/gpio_logic_array.sv
// gpio_logic_array: serially configured array of per-channel pad logic functions
module gpio_logic_array
    import gpio_logic_array_pkg::*;
#(
    parameter int NCH = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] a,
    input  logic [NCH-1:0] b,
    input  logic           cfg_en,
    input  logic           cfg_din,
    input  logic           cfg_load,
    output logic           cfg_ready,
    output logic [NCH-1:0] out,
    output logic [NCH-1:0] out_oeb
);
    localparam int W = CFG_BITS * NCH;
    localparam int CW = $clog2(W + 1);
    logic [W-1:0] shadow_q, shadow_d, active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic commit;
    assign cfg_ready = cnt_q == CW'(W);
    assign commit = cfg_load && cfg_ready;
    always_comb begin
        shadow_d = cfg_en ? {shadow_q[W-2:0], cfg_din} : shadow_q;
        active_d = commit ? shadow_q : active_q;
        cnt_d = commit                  ? CW'(cfg_en) :
                (cfg_en && !cfg_ready) ? cnt_q + CW'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gpio_logic_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .a_i   (a[i]),
            .b_i   (b[i]),
            .cfg_i (active_q[i*CFG_BITS +: CFG_BITS]),
            .clr_i (commit && shadow_q[i*CFG_BITS +: CFG_BITS] != active_q[i*CFG_BITS +: CFG_BITS]),
            .out_o (out[i]),
            .oeb_o (out_oeb[i])
        );
    end
endmodule

// File: tb/tb_gpio_logic_array.sv
// tb_gpio_logic_array: scoreboard bench with directed config frames and pad patterns
module tb_gpio_logic_array;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] a = '0, b = '0;
    logic cfg_en = 1'b0, cfg_din = 1'b0, cfg_load = 1'b0;
    logic cfg_ready;
    logic [3:0] out, out_oeb;
    typedef struct packed {
        logic [3:0] out;
        logic [3:0] oeb;
        logic       rdy;
    } exp_t;
    exp_t exp_q[$];
    string name_q[$];
    int checks = 0;
    int errors = 0;
    gpio_logic_array #(.NCH(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cfg_en    (cfg_en),
        .cfg_din   (cfg_din),
        .cfg_load  (cfg_load),
        .cfg_ready (cfg_ready),
        .out       (out),
        .out_oeb   (out_oeb)
    );
    always #5 clk = ~clk;
    function automatic void chk(string nm, string fld, logic [3:0] got, logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s got %b want %b", nm, fld, got, want);
        end
    endfunction
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            exp_t e;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "out", out, e.out);
            chk(nm, "out_oeb", out_oeb, e.oeb);
            chk(nm, "cfg_ready", {3'b0, cfg_ready}, {3'b0, e.rdy});
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic expect_now(input string nm, input logic [3:0] o, input logic [3:0] oe, input logic r);
        exp_q.push_back('{out: o, oeb: oe, rdy: r});
        name_q.push_back(nm);
    endtask
    task automatic shift(input logic [15:0] f, input int from, input int n);
        for (int k = from; k < from + n; k++) begin
            cfg_en = 1'b1;
            cfg_din = f[15-k];
            tick(1);
        end
        cfg_en = 1'b0;
        cfg_din = 1'b0;
    endtask
    task automatic load();
        cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0;
    endtask
    task automatic pulse_a0();
        a[0] = 1'b1;
        tick(1);
        a[0] = 1'b0;
        tick(3);
    endtask
    initial begin
        tick(2);
        rst = 1'b0;
        tick(1);
        expect_now("reset", 4'b0000, 4'b1111, 1'b0);
        shift(16'h8A9B, 0, 15);
        expect_now("partial_frame", 4'b0000, 4'b1111, 1'b0);
        load();
        expect_now("ignored_load", 4'b0000, 4'b1111, 1'b0);
        shift(16'h8A9B, 15, 1);
        expect_now("full_frame", 4'b0000, 4'b1111, 1'b1);
        load();
        expect_now("commit", 4'b0000, 4'b0000, 1'b0);
        tick(1);
        expect_now("idle_ops", 4'b0001, 4'b0000, 1'b0);
        a = 4'b1111; b = 4'b0101;
        tick(2);
        expect_now("latency_hold", 4'b0001, 4'b0000, 1'b0);
        tick(1);
        expect_now("ops_f_5", 4'b0010, 4'b0000, 1'b0);
        a = 4'b0011; b = 4'b1010;
        tick(3);
        expect_now("ops_3_a", 4'b0011, 4'b0000, 1'b0);
        a = 4'b1100; b = 4'b1100;
        tick(3);
        expect_now("ops_c_c", 4'b1001, 4'b0000, 1'b0);
        a = 4'b0000; b = 4'b0000;
        tick(3);
        cfg_en = 1'b1; cfg_din = 1'b1;
        tick(1);
        shift(16'h00FE, 0, 16);
        expect_now("saturate", 4'b0001, 4'b0000, 1'b1);
        load();
        expect_now("commit_tog_sr", 4'b0000, 4'b1100, 1'b0);
        b = 4'b0001;
        tick(3);
        pulse_a0();
        expect_now("toggle1", 4'b0001, 4'b1100, 1'b0);
        pulse_a0();
        expect_now("toggle2", 4'b0000, 4'b1100, 1'b0);
        pulse_a0();
        expect_now("toggle3", 4'b0001, 4'b1100, 1'b0);
        b = 4'b0000;
        tick(3);
        pulse_a0();
        expect_now("toggle_hold", 4'b0001, 4'b1100, 1'b0);
        a = 4'b0010; b = 4'b0010;
        tick(3);
        expect_now("sr_set_pri", 4'b0011, 4'b1100, 1'b0);
        a = 4'b0000;
        tick(3);
        expect_now("sr_clear", 4'b0001, 4'b1100, 1'b0);
        a = 4'b0010; b = 4'b0000;
        tick(3);
        a = 4'b0000;
        tick(3);
        expect_now("sr_hold", 4'b0011, 4'b1100, 1'b0);
        a = 4'b1100; b = 4'b1100;
        tick(3);
        expect_now("disabled", 4'b0011, 4'b1100, 1'b0);
        a = 4'b0000; b = 4'b0000;
        tick(3);
        shift(16'h08FE, 0, 16);
        load();
        expect_now("keep_unchanged", 4'b0011, 4'b1000, 1'b0);
        tick(1);
        expect_now("keep_after", 4'b0011, 4'b1000, 1'b0);
        shift(16'h08FF, 0, 16);
        load();
        expect_now("clear_changed", 4'b0010, 4'b1000, 1'b0);
        shift(16'hFFFF, 0, 8);
        rst = 1'b1; cfg_en = 1'b1; cfg_din = 1'b1; cfg_load = 1'b1;
        tick(1);
        rst = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0; cfg_load = 1'b0;
        expect_now("mid_reset", 4'b0000, 4'b1111, 1'b0);
        shift(16'h8A9B, 0, 15);
        expect_now("post_reset_cnt", 4'b0000, 4'b1111, 1'b0);
        shift(16'h8A9B, 15, 1);
        expect_now("post_reset_full", 4'b0000, 4'b1111, 1'b1);
        load();
        expect_now("post_reset_commit", 4'b0000, 4'b0000, 1'b0);
        tick(2);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout reached want finish");
        $fatal(1);
    end
endmodule
